audio_out_stage: RTL and testbench

AUDIO_OUT_STAGE -- requirements
Module: audio_out_stage

---
 rtl/audio_pkg.sv | 14 +
 rtl/sample_fifo.sv | 58 +++++
 rtl/audio_out_stage.sv | 112 +++++++++++
 tb/tb_audio_out_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio output stage: sample type,
// attenuation limit and the output FSM state encoding.
package audio_pkg;

   typedef logic signed [15:0] sample_t;

   localparam int unsigned ATTEN_MAX = 7;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } out_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Power-of-two sample FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sample_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  sample_t       push_data,
   input  logic          pop,
   output sample_t       pop_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   sample_t         mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     level_q, level_d;
   logic            do_push, do_pop;

   assign full     = (level_q == (AW+1)'(DEPTH));
   assign empty    = (level_q == '0);
   assign level    = level_q;
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: pointers and level define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push && !rst) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/audio_out_stage.sv
// Audio output stage: attenuate/mute strobed samples, buffer them, and hand
// them to the codec one stereo word per transfer. Volume control is built
// only when AUDIO_OUT_STAGE_VOLUME_EN is defined; otherwise attenuation is 0.
module audio_out_stage
   import audio_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [15:0]              sample_in,
   input  logic                     sample_strobe,
   input  logic                     vol_up,
   input  logic                     vol_down,
   input  logic                     mute,
   input  logic                     codec_ready,
   output logic                     codec_write,
   output logic [15:0]              codec_left,
   output logic [15:0]              codec_right,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   output out_state_t               state_dbg
);

   out_state_t state_q, state_d;
   sample_t    word_q, word_d;
   logic [2:0] atten_q, atten_d;
   logic       overflow_q, overflow_d;

   sample_t    sample_s, shifted, push_data, pop_data;
   logic       pop, push_ok, fifo_full, fifo_empty;

   always_comb begin
      atten_d = atten_q;
`ifdef AUDIO_OUT_STAGE_VOLUME_EN
      if (vol_up && !vol_down && atten_q != 3'd0) begin
         atten_d = atten_q - 3'd1;
      end else if (vol_down && !vol_up && atten_q != 3'(ATTEN_MAX)) begin
         atten_d = atten_q + 3'd1;
      end
`else
      atten_d = 3'd0;
`endif
   end

`ifndef AUDIO_OUT_STAGE_VOLUME_EN
   logic unused_vol;
   assign unused_vol = vol_up ^ vol_down;
`endif

   // The strobed sample is shifted by the attenuation held before this edge.
   always_comb begin
      sample_s   = sample_in;
      shifted    = sample_s >>> atten_q;
      push_data  = mute ? sample_t'(16'h0000) : shifted;
      pop        = (state_q == IDLE) && !fifo_empty;
      push_ok    = sample_strobe && (!fifo_full || pop);
      overflow_d = overflow_q | (sample_strobe && !push_ok);
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               state_d = WRITE;
               word_d  = pop_data;
            end
         end
         WRITE: begin
            if (codec_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         word_q     <= '0;
         atten_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         atten_q    <= atten_d;
         overflow_q <= overflow_d;
      end
   end

   sample_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_ok),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign codec_write = (state_q == WRITE);
   assign codec_left  = word_q;
   assign codec_right = word_q;
   assign overflow    = overflow_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_audio_out_stage.sv
// Directed bench for audio_out_stage: timing, volume, overflow, same-cycle
// push/pop, mute and reset behaviour, with an ordered queue of expected words.
module tb_audio_out_stage;
   import audio_pkg::*;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;
`ifdef AUDIO_OUT_STAGE_VOLUME_EN
   localparam bit VOL_EN = 1'b1;
`else
   localparam bit VOL_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   sample_in = '0;
   logic          sample_strobe = 1'b0;
   logic          vol_up = 1'b0;
   logic          vol_down = 1'b0;
   logic          mute = 1'b0;
   logic          codec_ready = 1'b0;
   logic          codec_write;
   logic [15:0]   codec_left, codec_right;
   logic [LW-1:0] fifo_level;
   logic          overflow;
   out_state_t    state_dbg;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [15:0]   exp_q[$];
   logic [15:0]   mon_exp;

   audio_out_stage #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .sample_in     (sample_in),
      .sample_strobe (sample_strobe),
      .vol_up        (vol_up),
      .vol_down      (vol_down),
      .mute          (mute),
      .codec_ready   (codec_ready),
      .codec_write   (codec_write),
      .codec_left    (codec_left),
      .codec_right   (codec_right),
      .fifo_level    (fifo_level),
      .overflow      (overflow),
      .state_dbg     (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [15:0] s);
      sample_in     = s;
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
   endtask

   task automatic pulse_down(input int n);
      for (int i = 0; i < n; i++) begin
         vol_down = 1'b1;
         tick();
         vol_down = 1'b0;
      end
   endtask

   task automatic pulse_up(input int n);
      for (int i = 0; i < n; i++) begin
         vol_up = 1'b1;
         tick();
         vol_up = 1'b0;
      end
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int i = 0; i < 64 && !done; i++) begin
         if (fifo_level == '0 && !codec_write && exp_q.size() == 0) done = 1'b1;
         else tick();
      end
      if (!done) check_eq("drain_timeout", 32'd0, 32'd1);
   endtask

   function automatic logic [15:0] vol_exp(input logic [15:0] with_vol, input logic [15:0] no_vol);
      return VOL_EN ? with_vol : no_vol;
   endfunction

   // Every codec transfer must match the next queued word, in order.
   always @(negedge clk) begin
      if (!rst && codec_write && codec_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_word", 32'd0, 32'd1);
         end else begin
            mon_exp = exp_q.pop_front();
            check_eq("codec_left", codec_left, mon_exp);
            check_eq("codec_right", codec_right, mon_exp);
         end
      end
   end

   initial begin
      tick();
      tick();
      rst = 1'b0;
      check_eq("rst_write", codec_write, 0);
      check_eq("rst_left", codec_left, 0);
      check_eq("rst_right", codec_right, 0);
      check_eq("rst_level", fifo_level, 0);
      check_eq("rst_overflow", overflow, 0);
      check_eq("rst_state", state_dbg, IDLE);

      // Latency: strobe in cycle N, word presented for exactly one cycle at N+2.
      codec_ready = 1'b1;
      exp_q.push_back(16'h1234);
      strobe(16'h1234);
      check_eq("lat_level_n1", fifo_level, 1);
      check_eq("lat_write_n1", codec_write, 0);
      tick();
      check_eq("lat_write_n2", codec_write, 1);
      check_eq("lat_left_n2", codec_left, 16'h1234);
      check_eq("lat_state_n2", state_dbg, WRITE);
      tick();
      check_eq("lat_write_n3", codec_write, 0);
      check_eq("lat_level_n3", fifo_level, 0);
      wait_drain();

      // Volume: saturation, simultaneous pulses, pre-update atten on strobe.
      pulse_down(3);
      exp_q.push_back(vol_exp(16'hF000, 16'h8000));
      strobe(16'h8000);
      wait_drain();
      pulse_down(8);
      exp_q.push_back(vol_exp(16'hFF00, 16'h8000));
      strobe(16'h8000);
      wait_drain();
      vol_up = 1'b1;
      vol_down = 1'b1;
      tick();
      vol_up = 1'b0;
      vol_down = 1'b0;
      exp_q.push_back(vol_exp(16'hFF00, 16'h8000));
      strobe(16'h8000);
      wait_drain();
      pulse_up(1);
      exp_q.push_back(vol_exp(16'hFE00, 16'h8000));
      vol_up = 1'b1;
      strobe(16'h8000);
      vol_up = 1'b0;
      wait_drain();
      exp_q.push_back(vol_exp(16'hFC00, 16'h8000));
      strobe(16'h8000);
      exp_q.push_back(vol_exp(16'h03FF, 16'h7FFF));
      strobe(16'h7FFF);
      wait_drain();
      pulse_up(8);
      exp_q.push_back(16'h8000);
      strobe(16'h8000);
      wait_drain();

      // Overflow: a parked word occupies the output register, then 5 strobes
      // fill the 4-entry FIFO and the 5th is dropped.
      codec_ready = 1'b0;
      exp_q.push_back(16'hAAAA);
      strobe(16'hAAAA);
      tick();
      check_eq("park_state", state_dbg, WRITE);
      check_eq("park_write", codec_write, 1);
      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back(16'(i));
         strobe(16'(i));
      end
      check_eq("full_level", fifo_level, 4);
      check_eq("full_overflow", overflow, 0);
      tick();
      check_eq("hold_left", codec_left, 16'hAAAA);
      strobe(16'h0005);
      check_eq("ovf_level", fifo_level, 4);
      check_eq("ovf_flag", overflow, 1);
      codec_ready = 1'b1;
      wait_drain();
      check_eq("ovf_sticky", overflow, 1);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rst2_overflow", overflow, 0);

      // Full FIFO: push accepted on the cycle that pops the head.
      codec_ready = 1'b0;
      exp_q.push_back(16'hB0B0);
      for (int i = 1; i <= 5; i++) exp_q.push_back(16'hC0C0 + 16'(i));
      strobe(16'hB0B0);
      tick();
      for (int i = 1; i <= 4; i++) strobe(16'hC0C0 + 16'(i));
      check_eq("pp_level_full", fifo_level, 4);
      codec_ready = 1'b1;
      tick();
      check_eq("pp_state_idle", state_dbg, IDLE);
      check_eq("pp_level_idle", fifo_level, 4);
      strobe(16'hC0C5);
      check_eq("pp_overflow", overflow, 0);
      check_eq("pp_level_after", fifo_level, 4);
      check_eq("pp_left", codec_left, 16'hC0C1);
      wait_drain();

      // Mute zeroes the captured sample.
      mute = 1'b1;
      exp_q.push_back(16'h0000);
      strobe(16'h7FFF);
      mute = 1'b0;
      wait_drain();

      // Reset mid-WRITE abandons the word; strobes/volume ignored under reset.
      codec_ready = 1'b0;
      strobe(16'hDEAD);
      tick();
      check_eq("mid_state", state_dbg, WRITE);
      strobe(16'hBEEF);
      check_eq("mid_level", fifo_level, 1);
      rst = 1'b1;
      sample_in = 16'h1111;
      sample_strobe = 1'b1;
      vol_down = 1'b1;
      tick();
      check_eq("rstw_write", codec_write, 0);
      check_eq("rstw_level", fifo_level, 0);
      check_eq("rstw_left", codec_left, 0);
      tick();
      rst = 1'b0;
      sample_strobe = 1'b0;
      vol_down = 1'b0;
      tick();
      check_eq("rstw_ign_level", fifo_level, 0);
      check_eq("rstw_ign_write", codec_write, 0);
      codec_ready = 1'b1;
      exp_q.push_back(16'h8000);
      strobe(16'h8000);
      wait_drain();

      check_eq("exp_q_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
